// File: rtl/conv3x3_seq.sv
// conv3x3_seq
// Time-multiplexed 3x3 convolution over a 5x5 unsigned feature map using a
// single 3-tap multiply-accumulate slice. One kernel row is accumulated per
// CALC cycle; each of the nine results is offered on a valid/ready port.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   start      job request, sampled only in IDLE
//   f          feature map, byte b = row b/5, col b%5
//   w          kernel, byte k
//   busy       high from the accept edge until back in IDLE
//   out_valid  result available on out_data/out_idx
//   out_ready  consumer accepts the offered result
//   out_data   result value
//   out_idx    output position 0..8 (3*R + C)
//   done       one-cycle pulse after the ninth transfer
module conv3x3_seq #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [25*DATA_W-1:0]  f,
  input  logic [9*DATA_W-1:0]   w,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic [3:0]            out_idx,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [25*DATA_W-1:0]  f_r, f_nxt_s;
  logic [9*DATA_W-1:0]   w_r, w_nxt_s;
  logic [3:0]            pos_r, pos_nxt_s;
  logic [1:0]            row_r, row_nxt_s;
  logic [ACC_W-1:0]      acc_r, acc_nxt_s;
  logic [ACC_W-1:0]      data_r, data_nxt_s;
  logic [3:0]            idx_r, idx_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  valid_r, valid_nxt_s;
  logic                  done_r, done_nxt_s;

  logic [1:0]            pos_row_s;
  logic [1:0]            pos_col_s;
  logic [2:0]            row_sum_s;
  logic [4:0]            feat_base_s;
  logic [3:0]            kern_base_s;
  logic [2*DATA_W-1:0]   prod_s;
  logic [ACC_W-1:0]      dot_s;

  function automatic logic [DATA_W-1:0] feat_byte(input logic [25*DATA_W-1:0] vec,
                                                  input logic [4:0] idx);
    return vec[idx*DATA_W +: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] kern_byte(input logic [9*DATA_W-1:0] vec,
                                                  input logic [3:0] idx);
    return vec[idx*DATA_W +: DATA_W];
  endfunction

  // 3-tap dot product of feature row R+row (cols C..C+2) with kernel row `row`.
  // The kernel is applied flipped: tap (i,j) uses byte 8-(3i+j).
  always_comb begin
    pos_row_s   = 2'(pos_r / 4'd3);
    pos_col_s   = 2'(pos_r % 4'd3);
    row_sum_s   = {1'b0, pos_row_s} + {1'b0, row_r};
    feat_base_s = {row_sum_s, 2'b00} + {2'b00, row_sum_s} + {3'b000, pos_col_s};
    kern_base_s = 4'd8 - {1'b0, row_r, 1'b0} - {2'b00, row_r};
    prod_s      = '0;
    dot_s       = '0;
    for (int j = 0; j < 3; j++) begin
      prod_s = feat_byte(f_r, feat_base_s + 5'(j)) * kern_byte(w_r, kern_base_s - 4'(j));
      dot_s  = dot_s + ACC_W'(prod_s);
    end
  end

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_nxt_s = state_r;
    f_nxt_s     = f_r;
    w_nxt_s     = w_r;
    pos_nxt_s   = pos_r;
    row_nxt_s   = row_r;
    acc_nxt_s   = acc_r;
    data_nxt_s  = data_r;
    idx_nxt_s   = idx_r;
    busy_nxt_s  = busy_r;
    valid_nxt_s = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          f_nxt_s     = f;
          w_nxt_s     = w;
          pos_nxt_s   = 4'd0;
          row_nxt_s   = 2'd0;
          acc_nxt_s   = '0;
          busy_nxt_s  = 1'b1;
          state_nxt_s = ST_CALC;
        end else begin
          busy_nxt_s  = 1'b0;
        end
      end
      ST_CALC: begin
        acc_nxt_s = acc_r + dot_s;
        if (row_r == 2'd2) begin
          data_nxt_s  = acc_r + dot_s;
          idx_nxt_s   = pos_r;
          valid_nxt_s = 1'b1;
          state_nxt_s = ST_OUT;
        end else begin
          row_nxt_s   = row_r + 2'd1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (pos_r == 4'd8) begin
            done_nxt_s  = 1'b1;
            state_nxt_s = ST_DONE;
          end else begin
            pos_nxt_s   = pos_r + 4'd1;
            row_nxt_s   = 2'd0;
            acc_nxt_s   = '0;
            state_nxt_s = ST_CALC;
          end
        end else begin
          // Hold the offer; data/idx registers are left untouched.
          valid_nxt_s = 1'b1;
        end
      end
      ST_DONE: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      f_r     <= '0;
      w_r     <= '0;
      pos_r   <= 4'd0;
      row_r   <= 2'd0;
      acc_r   <= '0;
      data_r  <= '0;
      idx_r   <= 4'd0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      f_r     <= f_nxt_s;
      w_r     <= w_nxt_s;
      pos_r   <= pos_nxt_s;
      row_r   <= row_nxt_s;
      acc_r   <= acc_nxt_s;
      data_r  <= data_nxt_s;
      idx_r   <= idx_nxt_s;
      busy_r  <= busy_nxt_s;
      valid_r <= valid_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign busy      = busy_r;
  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_idx   = idx_r;
  assign done      = done_r;

endmodule
